vscale_dmem_rr_arbiter: RTL and testbench

- Parametrised N-core successor to the two-core data-memory arbiter: merges NUM_CORES HASTI (AHB-lite) dmem master ports onto one shared dmem slave port.
- Round-robin address-phase grant, registered data-phase ownership, and hmastlock-held grants.
- Sits between the vscale_core dmem ports and the shared data memory in the multicore sim top; replaces the external next_core select with internal fair arbitration.

---
 rtl/vscale_dmem_rr_arbiter_pkg.sv | 33 +++
 rtl/vscale_dmem_rr_arbiter_rr_pick.sv | 27 ++
 rtl/vscale_dmem_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vscale_dmem_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_dmem_rr_arbiter_pkg.sv
// Shared HASTI encodings, widths and limits for the multicore dmem arbiter.
package vscale_dmem_rr_arbiter_pkg;

  localparam int unsigned MAX_CORES     = 8;
  localparam int unsigned HASTI_ADDR_W  = 32;
  localparam int unsigned HASTI_BUS_W   = 32;
  localparam int unsigned HASTI_SIZE_W  = 3;
  localparam int unsigned HASTI_BURST_W = 3;
  localparam int unsigned HASTI_PROT_W  = 4;
  localparam int unsigned HASTI_TRANS_W = 2;
  localparam int unsigned PERF_CNT_W    = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;

  // A transfer type that carries a real address phase.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_dmem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module vscale_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan offsets 0..N-1 from the pointer; the first hit wins.
  always_comb begin
    int unsigned j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned o = 0; o < N; o++) begin
      j = (32'(ptr) + o) % N;
      if (!valid && req[IDX_W'(j)]) begin
        idx   = IDX_W'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vscale_dmem_rr_arbiter.sv
// N-core HASTI dmem arbiter: round-robin address-phase grant, registered
// data-phase owner, hmastlock-held grants. Optional wait counters are built
// when VSCALE_ARB_PERF_CNT_EN is defined; otherwise perf_wait_cnt reads 0.
module vscale_dmem_rr_arbiter
  import vscale_dmem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BUS_W     = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_CORES*ADDR_W-1:0] core_haddr,
  input  logic [NUM_CORES-1:0]        core_hwrite,
  input  logic [NUM_CORES*3-1:0]      core_hsize,
  input  logic [NUM_CORES*3-1:0]      core_hburst,
  input  logic [NUM_CORES-1:0]        core_hmastlock,
  input  logic [NUM_CORES*4-1:0]      core_hprot,
  input  logic [NUM_CORES*2-1:0]      core_htrans,
  input  logic [NUM_CORES*BUS_W-1:0]  core_hwdata,
  output logic [NUM_CORES*BUS_W-1:0]  core_hrdata,
  output logic [NUM_CORES-1:0]        core_hready,
  output logic [NUM_CORES-1:0]        core_hresp,
  output logic [ADDR_W-1:0]           dmem_haddr,
  output logic                        dmem_hwrite,
  output logic [2:0]                  dmem_hsize,
  output logic [2:0]                  dmem_hburst,
  output logic                        dmem_hmastlock,
  output logic [3:0]                  dmem_hprot,
  output logic [1:0]                  dmem_htrans,
  output logic [BUS_W-1:0]            dmem_hwdata,
  input  logic [BUS_W-1:0]            dmem_hrdata,
  input  logic                        dmem_hready,
  input  logic                        dmem_hresp,
  output logic [IDX_W-1:0]            dmem_hmaster,
  output logic [NUM_CORES*PERF_CNT_W-1:0] perf_wait_cnt
);

  logic [NUM_CORES-1:0] req;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [IDX_W-1:0]     grant;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     rr_ptr;
  logic                 dp_valid;
  logic [IDX_W-1:0]     dp_owner;
  logic                 lock_valid;
  logic [IDX_W-1:0]     lock_owner;

  // Per-core request decode.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i] = htrans_active(core_htrans[i*2 +: 2]);
    end
  end

  vscale_rr_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // A held lock overrides round-robin, even while the owner is idle.
  always_comb begin
    grant     = lock_valid ? lock_owner : pick_idx;
    gnt_valid = lock_valid | pick_valid;
  end

  // Address-phase mux onto the shared slave.
  always_comb begin
    dmem_haddr     = '0;
    dmem_hwrite    = 1'b0;
    dmem_hsize     = '0;
    dmem_hburst    = '0;
    dmem_hmastlock = 1'b0;
    dmem_hprot     = '0;
    dmem_htrans    = HTRANS_IDLE;
    dmem_hmaster   = gnt_valid ? grant : '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt_valid && (grant == IDX_W'(i))) begin
        dmem_haddr     = core_haddr[i*ADDR_W +: ADDR_W];
        dmem_hwrite    = core_hwrite[i];
        dmem_hsize     = core_hsize[i*3 +: 3];
        dmem_hburst    = core_hburst[i*3 +: 3];
        dmem_hmastlock = core_hmastlock[i];
        dmem_hprot     = core_hprot[i*4 +: 4];
        dmem_htrans    = core_htrans[i*2 +: 2];
      end
    end
  end

  // Data-phase routing: write data from the owner, responses back to it.
  always_comb begin
    logic sel_a;
    logic sel_d;
    dmem_hwdata = '0;
    core_hrdata = {NUM_CORES{dmem_hrdata}};
    core_hready = '1;
    core_hresp  = '0;
    sel_a       = 1'b0;
    sel_d       = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sel_a = gnt_valid && (grant == IDX_W'(i));
      sel_d = dp_valid && (dp_owner == IDX_W'(i));
      if (sel_d) begin
        dmem_hwdata = core_hwdata[i*BUS_W +: BUS_W];
      end
      core_hresp[i] = sel_d ? dmem_hresp : HRESP_OKAY;
      if (req[i] && !sel_a) begin
        core_hready[i] = 1'b0;
      end else if (sel_a || sel_d) begin
        core_hready[i] = dmem_hready;
      end
    end
  end

  // Arbitration state advances only when the slave accepts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr     <= '0;
      dp_valid   <= 1'b0;
      dp_owner   <= '0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
    end else if (dmem_hready) begin
      if (gnt_valid) begin
        dp_valid   <= 1'b1;
        dp_owner   <= grant;
        rr_ptr     <= (grant == IDX_W'(NUM_CORES - 1)) ? '0 : grant + IDX_W'(1);
        lock_valid <= core_hmastlock[grant];
        lock_owner <= grant;
      end else begin
        dp_valid   <= 1'b0;
        lock_valid <= 1'b0;
      end
    end
  end

`ifdef VSCALE_ARB_PERF_CNT_EN
  logic [NUM_CORES-1:0] waiting;

  // A core waits when it requests but does not own the address phase.
  always_comb begin
    waiting = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      waiting[i] = req[i] && !(gnt_valid && (grant == IDX_W'(i)));
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_wait_cnt
    logic [PERF_CNT_W-1:0] cnt;

    // Saturating per-core wait counter.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt <= '0;
      end else if (waiting[g] && (cnt != '1)) begin
        cnt <= cnt + PERF_CNT_W'(1);
      end
    end

    assign perf_wait_cnt[g*PERF_CNT_W +: PERF_CNT_W] = cnt;
  end
`else
  assign perf_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_vscale_dmem_rr_arbiter.sv
// Randomised bench for vscale_dmem_rr_arbiter with a transaction-level reference model.
module tb_vscale_dmem_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 32;

  logic clk = 1'b0;
  logic resetn;

  logic [N*AW-1:0] core_haddr;
  logic [N-1:0]    core_hwrite;
  logic [N*3-1:0]  core_hsize;
  logic [N*3-1:0]  core_hburst;
  logic [N-1:0]    core_hmastlock;
  logic [N*4-1:0]  core_hprot;
  logic [N*2-1:0]  core_htrans;
  logic [N*BW-1:0] core_hwdata;
  logic [N*BW-1:0] core_hrdata;
  logic [N-1:0]    core_hready;
  logic [N-1:0]    core_hresp;
  logic [AW-1:0]   dmem_haddr;
  logic            dmem_hwrite;
  logic [2:0]      dmem_hsize;
  logic [2:0]      dmem_hburst;
  logic            dmem_hmastlock;
  logic [3:0]      dmem_hprot;
  logic [1:0]      dmem_htrans;
  logic [BW-1:0]   dmem_hwdata;
  logic [IW-1:0]   dmem_hmaster;
  logic [N*32-1:0] perf_wait_cnt;

  // Per-core stimulus and slave response.
  logic [31:0] t_addr  [N];
  logic        t_write [N];
  logic [2:0]  t_size  [N];
  logic [2:0]  t_burst [N];
  logic        t_lock  [N];
  logic [3:0]  t_prot  [N];
  logic [1:0]  t_trans [N];
  logic [31:0] t_wdata [N];
  logic        s_hready;
  logic        s_hresp;
  logic [31:0] s_hrdata;

  // Reference model state: whose turn it is, who owns the bus data phase, who holds a lock.
  int          m_turn;
  bit          m_dp_busy;
  int          m_dp_core;
  bit          m_locked;
  int          m_lock_core;
  longint unsigned m_wait [N];
  bit          exp_rdy [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      core_haddr[i*AW +: AW]  = t_addr[i];
      core_hwrite[i]          = t_write[i];
      core_hsize[i*3 +: 3]    = t_size[i];
      core_hburst[i*3 +: 3]   = t_burst[i];
      core_hmastlock[i]       = t_lock[i];
      core_hprot[i*4 +: 4]    = t_prot[i];
      core_htrans[i*2 +: 2]   = t_trans[i];
      core_hwdata[i*BW +: BW] = t_wdata[i];
    end
  end

  vscale_dmem_rr_arbiter #(.NUM_CORES(N), .IDX_W(IW), .ADDR_W(AW), .BUS_W(BW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .core_haddr     (core_haddr),
    .core_hwrite    (core_hwrite),
    .core_hsize     (core_hsize),
    .core_hburst    (core_hburst),
    .core_hmastlock (core_hmastlock),
    .core_hprot     (core_hprot),
    .core_htrans    (core_htrans),
    .core_hwdata    (core_hwdata),
    .core_hrdata    (core_hrdata),
    .core_hready    (core_hready),
    .core_hresp     (core_hresp),
    .dmem_haddr     (dmem_haddr),
    .dmem_hwrite    (dmem_hwrite),
    .dmem_hsize     (dmem_hsize),
    .dmem_hburst    (dmem_hburst),
    .dmem_hmastlock (dmem_hmastlock),
    .dmem_hprot     (dmem_hprot),
    .dmem_htrans    (dmem_htrans),
    .dmem_hwdata    (dmem_hwdata),
    .dmem_hrdata    (s_hrdata),
    .dmem_hready    (s_hready),
    .dmem_hresp     (s_hresp),
    .dmem_hmaster   (dmem_hmaster),
    .perf_wait_cnt  (perf_wait_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wants(input int c);
    return (t_trans[c] == 2'd2) || (t_trans[c] == 2'd3);
  endfunction

  // Lock holder wins; otherwise the requester closest after the turn pointer.
  task automatic model_grant(output int g, output bit gv);
    int best_d;
    g = 0;
    gv = 1'b0;
    best_d = N;
    if (m_locked) begin
      g  = m_lock_core;
      gv = 1'b1;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (wants(c) && (((c - m_turn + N) % N) < best_d)) begin
          best_d = (c - m_turn + N) % N;
          g      = c;
          gv     = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_turn      = 0;
    m_dp_busy   = 1'b0;
    m_dp_core   = 0;
    m_locked    = 1'b0;
    m_lock_core = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic model_step();
    int g;
    bit gv;
    model_grant(g, gv);
`ifdef VSCALE_ARB_PERF_CNT_EN
    for (int i = 0; i < N; i++) begin
      if (wants(i) && !(gv && g == i) && m_wait[i] < 64'hFFFF_FFFF) m_wait[i]++;
    end
`endif
    if (s_hready) begin
      if (gv) begin
        m_dp_busy   = 1'b1;
        m_dp_core   = g;
        m_turn      = (g + 1) % N;
        m_locked    = t_lock[g];
        m_lock_core = g;
      end else begin
        m_dp_busy = 1'b0;
        m_locked  = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int g;
    bit gv;
    bit own_a, own_d;
    logic [N-1:0] e_rdy, e_resp;
    model_grant(g, gv);
    check_eq("htrans", 64'(dmem_htrans), 64'(gv ? t_trans[g] : 2'd0));
    check_eq("hmaster", 64'(dmem_hmaster), 64'(gv ? g : 0));
    if (gv) begin
      check_eq("haddr", 64'(dmem_haddr), 64'(t_addr[g]));
      check_eq("hctl", 64'({dmem_hwrite, dmem_hsize, dmem_hburst, dmem_hmastlock, dmem_hprot}),
               64'({t_write[g], t_size[g], t_burst[g], t_lock[g], t_prot[g]}));
    end
    check_eq("hwdata", 64'(dmem_hwdata), 64'(m_dp_busy ? t_wdata[m_dp_core] : 32'd0));
    for (int i = 0; i < N; i++) begin
      own_a = gv && (g == i);
      own_d = m_dp_busy && (m_dp_core == i);
      if (wants(i) && !own_a) e_rdy[i] = 1'b0;
      else if (own_a || own_d) e_rdy[i] = s_hready;
      else e_rdy[i] = 1'b1;
      exp_rdy[i] = e_rdy[i];
      e_resp[i]  = own_d ? s_hresp : 1'b0;
      check_eq($sformatf("hrdata%0d", i), 64'(core_hrdata[i*BW +: BW]), 64'(s_hrdata));
`ifdef VSCALE_ARB_PERF_CNT_EN
      check_eq($sformatf("perf%0d", i), 64'(perf_wait_cnt[i*32 +: 32]), m_wait[i]);
`else
      check_eq($sformatf("perf%0d", i), 64'(perf_wait_cnt[i*32 +: 32]), 64'd0);
`endif
    end
    check_eq("hready", 64'(core_hready), 64'(e_rdy));
    check_eq("hresp", 64'(core_hresp), 64'(e_resp));
  endtask

  task automatic set_core(input int i, input logic [1:0] tr, input logic [31:0] a,
                          input logic w, input logic lk);
    t_trans[i] = tr;
    t_addr[i]  = a;
    t_write[i] = w;
    t_lock[i]  = lk;
    t_size[i]  = 3'd2;
    t_burst[i] = 3'd0;
    t_prot[i]  = 4'h3;
  endtask

  // New random transfer for each core that is not stalled; stalled cores hold.
  task automatic randomize_inputs();
    int r;
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        r = int'($urandom_range(0, 7));
        t_trans[i] = (r < 3) ? 2'd0 : (r == 3) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
        t_addr[i]  = $urandom;
        t_write[i] = 1'($urandom);
        t_size[i]  = 3'($urandom_range(0, 2));
        t_burst[i] = 3'd0;
        t_prot[i]  = 4'($urandom);
        t_wdata[i] = $urandom;
        if (m_locked && m_lock_core == i) t_lock[i] = 1'($urandom);
        else t_lock[i] = ($urandom_range(0, 7) == 0);
      end
    end
    s_hready = ($urandom_range(0, 3) != 0);
    s_hresp  = ($urandom_range(0, 7) == 0);
    s_hrdata = $urandom;
  endtask

  initial begin
    resetn   = 1'b0;
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = 32'hDEAD_BEEF;
    for (int i = 0; i < N; i++) begin
      set_core(i, 2'd0, 32'd0, 1'b0, 1'b0);
      t_wdata[i] = 32'h1000_0000 + 32'(i);
      exp_rdy[i] = 1'b1;
    end
    model_reset();

    // Reset state.
    @(negedge clk);
    #1 check_all();
    resetn = 1'b1;

    // All four requesting continuously: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) set_core(i, 2'd2, 32'h100 + 32'(4 * i + 16 * k), 1'b0, 1'b0);
      #1 check_all();
      check_eq("rr_order", 64'(dmem_hmaster), 64'(k % 4));
`ifdef VSCALE_ARB_PERF_CNT_EN
      if (k == 4) check_eq("perf3_after4", 64'(perf_wait_cnt[3*32 +: 32]), 64'd3);
`endif
      @(posedge clk);
      model_step();
    end

    // Core1 locks for three transfers while core0 waits, then releases with IDLE.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_core(2, 2'd0, 32'd0, 1'b0, 1'b0);
      set_core(3, 2'd0, 32'd0, 1'b0, 1'b0);
      set_core(0, 2'd2, 32'h200, 1'b0, 1'b0);
      if (k < 3) set_core(1, 2'd2, 32'h300 + 32'(4 * k), 1'b1, 1'b1);
      else set_core(1, 2'd0, 32'd0, 1'b0, 1'b0);
      #1 check_all();
      check_eq("lock_owner", 64'(dmem_hmaster), 64'((k < 4) ? 1 : 0));
      if (k < 4) check_eq("lock_stall0", 64'(core_hready[0]), 64'd0);
      @(posedge clk);
      model_step();
    end

    // Slave stalls two cycles during core0's data phase; write data must hold.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_core(0, 2'd0, 32'd0, 1'b0, 1'b0);
      set_core(2, 2'd2, 32'h400, 1'b1, 1'b0);
      t_wdata[0] = 32'hA5A5_0000;
      s_hready   = (k == 2);
      #1 check_all();
      check_eq("stall_hwdata", 64'(dmem_hwdata), 64'h0000_0000_A5A5_0000);
      if (k < 2) check_eq("stall_rdy", 64'({core_hready[2], core_hready[0]}), 64'd0);
      @(posedge clk);
      model_step();
    end

    // Randomised traffic with occasional asynchronous resets mid-cycle.
    for (int i = 0; i < N; i++) exp_rdy[i] = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      randomize_inputs();
      #1 check_all();
      if ($urandom_range(0, 49) == 0) begin
        resetn = 1'b0;
        model_reset();
        #1 check_all();
        #1 resetn = 1'b1;
      end
      @(posedge clk);
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
